// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: output sample format, default
// fixed-point scaling and the accumulator width rule.
package fir_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  // Q15 coefficients: the accumulator carries 15 fractional bits.
  localparam int DEFAULT_FRAC_SHIFT = 15;

  // Accumulator width: one product plus enough growth bits for TAPS terms.
  function automatic int accu_bits(input int taps, input int multbits);
    return multbits + $clog2(taps);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. rd_data always shows the head
// entry while not empty. A write to a full FIFO is dropped unless a read
// happens on the same edge. Memory is not reset; only pointers and count are.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fir_output_stage.sv
// FIR output conditioning: round-half-up, rescale by FRAC_SHIFT, saturate to
// 16 bits, then buffer in a small FWFT FIFO behind credit-based flow control.
//
// Handshake: both ports are valid/ready. A transfer happens on a rising edge
// where valid && ready. A producer holding valid must keep its data stable
// until the transfer. in_ready depends only on registered state (never on
// out_ready), so the two pipeline stages never stall. A pop in the same cycle
// is not credited, which costs nothing at steady state (occupancy 3 of 4).
module fir_output_stage
  import fir_pkg::*;
#(
  parameter int  TAPS       = 401,
  parameter int  MULTBITS   = 32,
  parameter int  FRAC_SHIFT = DEFAULT_FRAC_SHIFT,
  parameter int  FIFO_DEPTH = 4,
  localparam int ACCUBITS   = accu_bits(TAPS, MULTBITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [ACCUBITS-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_sample,
  input  logic                clr_sat,
  output logic                sat_flag
);

  // One guard bit so adding the rounding constant to the max input cannot wrap.
  localparam int RW = ACCUBITS + 1;
  localparam int FW = SAMPLE_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [RW-1:0] ROUND = RW'(1) << (FRAC_SHIFT - 1);

  logic                 in_accept;
  logic                 v1;
  logic signed [RW-1:0] r1;
  logic                 v2;
  logic [FW-1:0]        d2;

  logic signed [RW-1:0]    s_shift;
  logic [RW-SAMPLE_W:0]    s_upper;
  logic                    s_fits;
  logic [SAMPLE_W-1:0]     sample_c;
  logic                    sat_c;

  logic [FW-1:0] fifo_head;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ;

  assign in_accept = in_valid && in_ready;

  // Credits: everything already committed downstream, from registered state.
  assign occ      = (CW+1)'(fifo_count) + (CW+1)'(v1) + (CW+1)'(v2);
  assign in_ready = (occ < (CW+1)'(FIFO_DEPTH));

  // Rescale stage-1 value and clamp anything outside the 16-bit sample range.
  always_comb begin
    s_shift  = r1 >>> FRAC_SHIFT;
    s_upper  = s_shift[RW-1:SAMPLE_W-1];
    s_fits   = (&s_upper) || !(|s_upper);
    sat_c    = !s_fits;
    sample_c = s_shift[SAMPLE_W-1:0];
    if (!s_fits) begin
      sample_c = s_shift[RW-1] ? SAMPLE_MIN : SAMPLE_MAX;
    end
  end

  // Two always-advancing pipeline stages: round, then shift/saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      r1 <= '0;
      v2 <= 1'b0;
      d2 <= '0;
    end else begin
      v1 <= in_accept;
      r1 <= $signed({in_data[ACCUBITS-1], in_data}) + ROUND;
      v2 <= v1;
      d2 <= {sat_c, sample_c};
    end
  end

  // Sticky saturation flag; a saturated write on the clearing edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (v2 && d2[FW-1]) begin
      sat_flag <= 1'b1;
    end else if (clr_sat) begin
      sat_flag <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (v2),
    .wr_data (d2),
    .rd_en   (out_ready),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Head word is shown only while valid so unwritten memory never leaks out.
  assign out_valid  = !fifo_empty;
  assign out_sample = fifo_empty ? '0 : fifo_head[SAMPLE_W-1:0];

endmodule
